prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder for the 8-bit core.
- Receives a program as a byte stream over a valid/ready handshake and assembles it into the 72-bit machine_code image: 9 instructions × 8 bits.
- Holds the core in reset while loading, and commits the image atomically.
- Its outputs drive the core top's machine_code and rst inputs directly.

Parameters:
- NUM_INSTR, 9, number of 8-bit instructions in the image.
- INSTR_W, 8, instruction width in bits.
- TIMEOUT_CYC, 255, maximum idle cycles between accepted bytes during a load before the load is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (one clock; asserted at 0).
- load_start  in  1  one-cycle pulse that begins or restarts a load.
- byte_in  in  8  program byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- machine_code  out  72  committed program image to the core.
- core_rst  out  1  active-high reset to the core top.
- load_done  out  1  image committed; core released.
- load_err  out  1  last load aborted (timeout, or checksum mismatch when enabled).
- byte_cnt  out  4  bytes accepted in the current load.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - machine_code=0, core_rst=1, load_done=0, load_err=0, byte_ready=0, byte_cnt=0, shadow buffer=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE:
  - byte_ready=0, core_rst=1.
  - load_start -> LOAD; clear byte_cnt, shadow, timer and load_err.
- LOAD:
  - byte_ready=1, core_rst=1, load_done=0.
  - Transfer occurs on a rising edge with byte_valid & byte_ready.
  - Byte k (0-based) is written to shadow[8k+7:8k], so instruction 0 (PC=0) is the LSB byte. byte_cnt increments.
  - After the transfer that makes byte_cnt reach NUM_INSTR, on the same edge:
    - shadow including that byte -> machine_code
    - load_done=1, core_rst=0, byte_ready=0
    - state -> DONE
  - machine_code never changes mid-load.
  - Timer increments each LOAD cycle without a transfer and clears on any transfer. Reaching TIMEOUT_CYC -> ERROR.
  - load_start in LOAD restarts: byte_cnt=0, timer=0, shadow=0. A byte presented in the same cycle is ignored (load_start wins).
- DONE:
  - Holds machine_code, core_rst=0, byte_ready=0.
  - load_start -> LOAD; core_rst=1 and load_done=0 on the next edge.
  - Old machine_code is retained until the new commit.
- ERROR:
  - load_err=1, core_rst=1, load_done=0, byte_ready=0.
  - machine_code keeps its last committed value.
  - Exits only via load_start (-> LOAD, load_err cleared) or reset.
- Latency: the final byte is accepted at edge N; machine_code, load_done and core_rst are updated at edge N. The core sees reset released from cycle N+1.
- byte_valid while byte_ready=0 is ignored; there is no buffering.
- byte_cnt saturates at NUM_INSTR (plus 1 when the checksum feature is enabled). No wrap.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined:
  - LOAD expects NUM_INSTR+1 bytes. The final byte is a checksum equal to the sum mod 256 of the NUM_INSTR program bytes.
  - Match -> commit as above.
  - Mismatch -> ERROR with no commit.
  - The running sum is cleared with the shadow.
- Undefined: no checksum byte; commit after NUM_INSTR bytes.

Decomposition:
- Package prog_loader_pkg:
  - State encoding constants IDLE/LOAD/DONE/ERROR.
  - INSTR_W and NUM_INSTR defaults.
  - IMG_W = NUM_INSTR*INSTR_W.
- One natural sub-module: prog_loader_timer, a clearable saturating idle counter with a terminal-count output.
- Shadow, checksum and FSM logic stay in the top.

Test Plan:
- Reset, load_start, then bytes A9,25,04,D8,4D,21,34,03,00 back-to-back -> machine_code=72'h00_03_34_21_4D_D8_04_25_A9, load_done=1 and core_rst=0 at the edge accepting byte 9; byte_cnt=9.
- Same program with byte_valid gaps of 3 cycles -> identical image; machine_code stays 0 until the last byte.
- After a commit, load_start, 4 bytes, then idle TIMEOUT_CYC cycles -> load_err=1, core_rst=1, machine_code still holds the previous image.
- load_start asserted after 5 bytes, then a full 9-byte program of all 8'h11 -> machine_code=72'h111111111111111111.
- rst pulled low mid-load (after 6 bytes) -> all outputs immediately reset values; byte_ready=0.
- With PROG_LOADER_CHECKSUM_EN: the first program followed by 8'h4F -> commit. Followed by 8'h50 instead -> ERROR, no commit.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
// Build option PROG_LOADER_CHECKSUM_EN appends a mod-256 checksum byte to each load.
package prog_loader_pkg;

  localparam int INSTR_W     = 8;
  localparam int NUM_INSTR   = 9;
  localparam int IMG_W       = NUM_INSTR * INSTR_W;
  localparam int TIMEOUT_CYC = 255;
  localparam int CNT_W       = 4;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int NUM_BYTES = NUM_INSTR + 1;
`else
  localparam int NUM_BYTES = NUM_INSTR;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/prog_loader_timer.sv
// Clearable saturating idle counter; expire pulses on the increment that reaches TC.
module prog_loader_timer #(
  parameter int TC = 255,
  parameter int W  = $clog2(TC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != W'(TC))) begin
      count_d = count_q + W'(1);
    end
  end

  assign expire = inc && !clr && (count_q == W'(TC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles the core image in a shadow buffer and commits it atomically.
// Build option PROG_LOADER_CHECKSUM_EN: expect a trailing checksum byte, commit only on match.
//
// state    | meaning
// ST_IDLE  | no load yet, core held in reset
// ST_LOAD  | accepting bytes into the shadow buffer, core held in reset
// ST_DONE  | image committed, core running
// ST_ERROR | last load aborted, core held in reset, old image kept
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [INSTR_W-1:0] byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [IMG_W-1:0]   machine_code,
  output logic               core_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [CNT_W-1:0]   byte_cnt
);

  state_e             state_q, state_d;
  logic [IMG_W-1:0]   shadow_q, shadow_d;
  logic [IMG_W-1:0]   machine_code_q, machine_code_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               byte_ready_q, byte_ready_d;
  logic               core_rst_q, core_rst_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_q, sum_d;
`endif

  logic               transfer;
  logic               last_byte;
  logic               timer_clr, timer_inc, timer_expire;
  logic               do_enter, do_commit, do_error;
  logic [IMG_W-1:0]   shadow_wr;
  logic [IMG_W-1:0]   commit_img;

  // byte_ready_q is only ever set while in ST_LOAD, so it qualifies the transfer on its own
  assign transfer  = byte_valid && byte_ready_q && !load_start;
  assign last_byte = (byte_cnt_q == CNT_W'(NUM_BYTES - 1));
  assign timer_clr = load_start || transfer;
  assign timer_inc = (state_q == ST_LOAD) && !transfer && !load_start;

  prog_loader_timer #(.TC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expire (timer_expire)
  );

  always_comb begin
    shadow_wr = shadow_q;
    for (int i = 0; i < NUM_INSTR; i++) begin
      if (byte_cnt_q == CNT_W'(i)) begin
        shadow_wr[i*INSTR_W +: INSTR_W] = byte_in;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    machine_code_d = machine_code_q;
    byte_cnt_d     = byte_cnt_q;
    byte_ready_d   = byte_ready_q;
    core_rst_d     = core_rst_q;
    load_done_d    = load_done_q;
    load_err_d     = load_err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    do_enter   = 1'b0;
    do_commit  = 1'b0;
    do_error   = 1'b0;
    commit_img = shadow_wr;

    case (state_q)
      ST_LOAD: begin
        if (load_start) begin
          do_enter = 1'b1;
        end else if (transfer) begin
          if (byte_cnt_q != CNT_W'(NUM_BYTES)) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          if (last_byte) begin
            commit_img = shadow_q;
            if (byte_in == sum_q) begin
              do_commit = 1'b1;
            end else begin
              do_error = 1'b1;
            end
          end else begin
            shadow_d = shadow_wr;
            sum_d    = sum_q + byte_in;
          end
`else
          shadow_d = shadow_wr;
          if (last_byte) begin
            do_commit = 1'b1;
          end
`endif
        end else if (timer_expire) begin
          do_error = 1'b1;
        end
      end
      default: begin
        if (load_start) begin
          do_enter = 1'b1;
        end
      end
    endcase

    if (do_enter) begin
      state_d      = ST_LOAD;
      shadow_d     = '0;
      byte_cnt_d   = '0;
      byte_ready_d = 1'b1;
      core_rst_d   = 1'b1;
      load_done_d  = 1'b0;
      load_err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d        = '0;
`endif
    end
    if (do_commit) begin
      state_d        = ST_DONE;
      machine_code_d = commit_img;
      byte_ready_d   = 1'b0;
      core_rst_d     = 1'b0;
      load_done_d    = 1'b1;
    end
    if (do_error) begin
      state_d      = ST_ERROR;
      byte_ready_d = 1'b0;
      core_rst_d   = 1'b1;
      load_done_d  = 1'b0;
      load_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '0;
      machine_code_q <= '0;
      byte_cnt_q     <= '0;
      byte_ready_q   <= 1'b0;
      core_rst_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      machine_code_q <= machine_code_d;
      byte_cnt_q     <= byte_cnt_d;
      byte_ready_q   <= byte_ready_d;
      core_rst_q     <= core_rst_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign machine_code = machine_code_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN when it is defined.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam logic [71:0] IMG1 = 72'h00_03_34_21_4D_D8_04_25_A9;
  localparam logic [71:0] IMG2 = 72'h11_11_11_11_11_11_11_11_11;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [IMG_W-1:0] machine_code;
  logic             core_rst;
  logic             load_done;
  logic             load_err;
  logic [3:0]       byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .machine_code (machine_code),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .byte_cnt     (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_ready", 72'(byte_ready), 72'd1);
    check("start_cnt", 72'(byte_cnt), 72'd0);
    check("start_core_rst", 72'(core_rst), 72'd1);
    check("start_err", 72'(load_err), 72'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    if (byte_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready: got %b expected 1", byte_ready);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  // Full load after a start pulse; checks the image is held until the final byte.
  task automatic load_program(input logic [71:0] img, input int gap, input logic [7:0] csum,
                              input bit expect_ok, input logic [71:0] prev);
    for (int k = 0; k < NUM_INSTR; k++) begin
      send_byte(img[8*k +: 8], gap);
      if (k == 3) check("mid_image", machine_code, prev);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    check("pre_csum_image", machine_code, prev);
    check("pre_csum_done", 72'(load_done), 72'd0);
    send_byte(csum, gap);
`else
    if (csum != 8'h00) check("csum_unused", 72'(byte_cnt), 72'(NUM_BYTES));
`endif
    check("final_cnt", 72'(byte_cnt), 72'(NUM_BYTES));
    check("final_ready", 72'(byte_ready), 72'd0);
    if (expect_ok) begin
      check("commit_image", machine_code, img);
      check("commit_done", 72'(load_done), 72'd1);
      check("commit_core_rst", 72'(core_rst), 72'd0);
    end else begin
      check("reject_image", machine_code, prev);
      check("reject_err", 72'(load_err), 72'd1);
      check("reject_core_rst", 72'(core_rst), 72'd1);
      check("reject_done", 72'(load_done), 72'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) tick();
    check("rst_image", machine_code, 72'd0);
    check("rst_core_rst", 72'(core_rst), 72'd1);
    check("rst_done", 72'(load_done), 72'd0);
    check("rst_err", 72'(load_err), 72'd0);
    check("rst_ready", 72'(byte_ready), 72'd0);
    check("rst_cnt", 72'(byte_cnt), 72'd0);
    rst = 1'b1;
    tick();

    // valid while idle is ignored
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    tick();
    byte_valid = 1'b0;
    check("idle_ignore_cnt", 72'(byte_cnt), 72'd0);

    pulse_start();
    load_program(IMG1, 0, 8'h4F, 1'b1, 72'd0);

    // valid while done is ignored
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    tick();
    byte_valid = 1'b0;
    check("done_ignore_cnt", 72'(byte_cnt), 72'(NUM_BYTES));
    check("done_ignore_image", machine_code, IMG1);

    do_reset();
    pulse_start();
    load_program(IMG1, 3, 8'h4F, 1'b1, 72'd0);

    // timeout after 4 bytes with a committed image in place
    pulse_start();
    check("reload_done_low", 72'(load_done), 72'd0);
    check("reload_image_kept", machine_code, IMG1);
    for (int k = 0; k < 4; k++) send_byte(IMG2[8*k +: 8], 0);
    check("partial_cnt", 72'd4, 72'(byte_cnt));
    repeat (TIMEOUT_CYC - 1) tick();
    check("pre_timeout_err", 72'(load_err), 72'd0);
    check("pre_timeout_ready", 72'(byte_ready), 72'd1);
    tick();
    check("timeout_err", 72'(load_err), 72'd1);
    check("timeout_core_rst", 72'(core_rst), 72'd1);
    check("timeout_ready", 72'(byte_ready), 72'd0);
    check("timeout_image", machine_code, IMG1);

    // restart mid-load; byte presented with load_start is dropped
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(8'hFF, 0);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    check("restart_cnt", 72'(byte_cnt), 72'd0);
    check("restart_ready", 72'(byte_ready), 72'd1);
    load_program(IMG2, 0, 8'h99, 1'b1, IMG1);

    // asynchronous reset mid-load
    pulse_start();
    for (int k = 0; k < 6; k++) send_byte(IMG1[8*k +: 8], 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_ready", 72'(byte_ready), 72'd0);
    check("async_cnt", 72'(byte_cnt), 72'd0);
    check("async_image", machine_code, 72'd0);
    check("async_core_rst", 72'(core_rst), 72'd1);
    check("async_done", 72'(load_done), 72'd0);
    tick();
    rst = 1'b1;
    tick();

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    load_program(IMG1, 0, 8'h4F, 1'b1, 72'd0);
    pulse_start();
    load_program(IMG2, 1, 8'h50, 1'b0, IMG1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
